// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: adder-mode encoding and pipeline depth helper.
package arith_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int unsigned stages_f(input int unsigned n, input int unsigned seg);
        return n / seg;
    endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline stage: SEG-bit ripple-carry add of one operand segment plus its
// registered valid, carry-out, running all-zero flag and segment sum.
module pipe_add_stage #(
    parameter int unsigned SEG = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic           valid_i,
    input  logic           carry_i,
    input  logic           zero_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    output logic           valid_o,
    output logic           carry_o,
    output logic           zero_o,
    output logic [SEG-1:0] sum_o
);

    logic [SEG:0]   c;
    logic [SEG-1:0] sum_d;
    logic           valid_d, carry_d, zero_d;
    logic           valid_q, carry_q, zero_q;
    logic [SEG-1:0] sum_q;

    always_comb begin
        c     = '0;
        sum_d = '0;
        c[0]  = carry_i;
        for (int unsigned i = 0; i < SEG; i++) begin
            sum_d[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        valid_d = valid_i;
        carry_d = c[SEG];
        // zero_i says every lower segment of this beat was zero
        zero_d  = zero_i && (sum_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            sum_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            sum_q   <= sum_d;
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign zero_o  = zero_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/subtract split into N/SEG carry-registered segments, one per stage,
// with valid/ready handshake and full backpressure via a global stage enable.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned SEG = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    input  logic         sub_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] s_o,
    output logic         c_o,
    output logic         v_o,
    output logic         z_o
);

    localparam int unsigned STAGES = stages_f(N, SEG);

    if ((N % SEG) != 0) begin : g_bad_width
        $error("pipelined_adder: N (%0d) must be a multiple of SEG (%0d)", N, SEG);
    end

    logic           en;
    logic [N-1:0]   b_eff;
    logic           cin;
    logic [STAGES:0] valid_c, carry_c, zero_c;
    logic [SEG-1:0] a_seg   [STAGES];
    logic [SEG-1:0] b_seg   [STAGES];
    logic [SEG-1:0] sum_seg [STAGES];
    logic [SEG-1:0] out_seg [STAGES];
    logic           am_q, bm_q;

    assign en         = !valid_c[STAGES] || ready_i;
    assign ready_o    = en;
    assign b_eff      = (sub_i == SUB) ? ~b_i : b_i;
    assign cin        = c_i ^ sub_i;
    assign valid_c[0] = valid_i;
    assign carry_c[0] = cin;
    assign zero_c[0]  = 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned KU  = k;
        localparam int unsigned LSB = KU * SEG;
        localparam int unsigned DLY = STAGES - 1 - KU;

        // Segment k of the operands waits k cycles so it meets the carry from stage k-1
        if (KU == 0) begin : g_head
            assign a_seg[k] = a_i[SEG-1:0];
            assign b_seg[k] = b_eff[SEG-1:0];
        end else begin : g_skew
            logic [SEG-1:0] sa_q [KU];
            logic [SEG-1:0] sb_q [KU];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int unsigned d = 0; d < KU; d++) begin
                        sa_q[d] <= '0;
                        sb_q[d] <= '0;
                    end
                end else if (en) begin
                    sa_q[0] <= a_i[LSB +: SEG];
                    sb_q[0] <= b_eff[LSB +: SEG];
                    for (int unsigned d = 1; d < KU; d++) begin
                        sa_q[d] <= sa_q[d-1];
                        sb_q[d] <= sb_q[d-1];
                    end
                end
            end
            assign a_seg[k] = sa_q[KU-1];
            assign b_seg[k] = sb_q[KU-1];
        end

        pipe_add_stage #(.SEG(SEG)) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en),
            .valid_i (valid_c[k]),
            .carry_i (carry_c[k]),
            .zero_i  (zero_c[k]),
            .a_i     (a_seg[k]),
            .b_i     (b_seg[k]),
            .valid_o (valid_c[k+1]),
            .carry_o (carry_c[k+1]),
            .zero_o  (zero_c[k+1]),
            .sum_o   (sum_seg[k])
        );

        if (DLY == 0) begin : g_tail
            assign out_seg[k] = sum_seg[k];
        end else begin : g_deskew
            logic [SEG-1:0] ds_q [DLY];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int unsigned d = 0; d < DLY; d++) begin
                        ds_q[d] <= '0;
                    end
                end else if (en) begin
                    ds_q[0] <= sum_seg[k];
                    for (int unsigned d = 1; d < DLY; d++) begin
                        ds_q[d] <= ds_q[d-1];
                    end
                end
            end
            assign out_seg[k] = ds_q[DLY-1];
        end
    end

    always_comb begin
        s_o = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            s_o[k*SEG +: SEG] = out_seg[k];
        end
    end

    // Operand MSBs travel with the top segment; with the result MSB they give
    // the carry into bit N-1, so overflow = same-sign operands, different-sign result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            am_q <= 1'b0;
            bm_q <= 1'b0;
        end else if (en) begin
            am_q <= a_seg[STAGES-1][SEG-1];
            bm_q <= b_seg[STAGES-1][SEG-1];
        end
    end

    assign valid_o = valid_c[STAGES];
    assign c_o     = carry_c[STAGES];
    assign z_o     = zero_c[STAGES];
    assign v_o     = (am_q == bm_q) && (s_o[N-1] != am_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three configurations (32/8, 16/16, 64/4) checked
// every cycle against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_adder;
    import arith_pkg::*;

    localparam int unsigned NW [3]  = '{32, 16, 64};
    localparam int unsigned SW [3]  = '{8, 16, 4};
    localparam int unsigned BEATS   = 10000;
    localparam int unsigned RING    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vin, rin, cin_b, sub_b;
    logic [63:0] a_in [3];
    logic [63:0] b_in [3];
    logic [2:0]  rout, vout, co, vo, zo;
    logic [31:0] s0;
    logic [15:0] s1;
    logic [63:0] s2;
    logic [63:0] s_all [3];

    int cmp_cnt = 0;
    int err_cnt = 0;

    int unsigned wr [3];
    int unsigned rd [3];
    logic [66:0] exp_mem [3][RING];
    logic        held [3];
    logic [66:0] held_v [3];

    always #5 clk = ~clk;

    always_comb begin
        s_all[0] = {32'b0, s0};
        s_all[1] = {48'b0, s1};
        s_all[2] = s2;
    end

    pipelined_adder #(.N(32), .SEG(8)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .ready_o(rout[0]),
        .a_i(a_in[0][31:0]), .b_i(b_in[0][31:0]), .c_i(cin_b[0]), .sub_i(sub_b[0]),
        .valid_o(vout[0]), .ready_i(rin[0]), .s_o(s0), .c_o(co[0]), .v_o(vo[0]), .z_o(zo[0])
    );

    pipelined_adder #(.N(16), .SEG(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .ready_o(rout[1]),
        .a_i(a_in[1][15:0]), .b_i(b_in[1][15:0]), .c_i(cin_b[1]), .sub_i(sub_b[1]),
        .valid_o(vout[1]), .ready_i(rin[1]), .s_o(s1), .c_o(co[1]), .v_o(vo[1]), .z_o(zo[1])
    );

    pipelined_adder #(.N(64), .SEG(4)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[2]), .ready_o(rout[2]),
        .a_i(a_in[2]), .b_i(b_in[2]), .c_i(cin_b[2]), .sub_i(sub_b[2]),
        .valid_o(vout[2]), .ready_i(rin[2]), .s_o(s2), .c_o(co[2]), .v_o(vo[2]), .z_o(zo[2])
    );

    // Reference: plain wide arithmetic, result packed as {z, v, c, s}
    function automatic logic [66:0] model(input int unsigned n, input logic [63:0] a,
                                          input logic [63:0] b, input logic c, input logic sub);
        logic [64:0] mask, am, bm, sum, lo_mask, lo;
        logic        carry_out, carry_msb;
        logic [63:0] s;
        mask      = (65'd1 << n) - 65'd1;
        am        = {1'b0, a} & mask;
        bm        = {1'b0, (sub ? ~b : b)} & mask;
        sum       = am + bm + 65'(c ^ sub);
        carry_out = sum[n];
        lo_mask   = mask >> 1;
        lo        = (am & lo_mask) + (bm & lo_mask) + 65'(c ^ sub);
        carry_msb = lo[n-1];
        s         = sum[63:0] & mask[63:0];
        return {s == 64'd0, carry_msb ^ carry_out, carry_out, s};
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare: handshake rule, hold-while-stalled, in-order results
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [66:0] act;
            act = {zo[i], vo[i], co[i], s_all[i]};
            if (rst) begin
                wr[i]   = 0;
                rd[i]   = 0;
                held[i] = 1'b0;
            end else begin
                check($sformatf("ready_o[%0d]", i), 67'(rout[i]), 67'(!(vout[i] && !rin[i])));
                if (held[i]) begin
                    check($sformatf("hold_valid[%0d]", i), 67'(vout[i]), 67'(1));
                    check($sformatf("hold_data[%0d]", i), act, held_v[i]);
                end
                if (vout[i] && rin[i]) begin
                    if (rd[i] == wr[i]) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL spurious[%0d]: got valid_o=1, expected no beat in flight", i);
                    end else begin
                        check($sformatf("result[%0d]", i), act, exp_mem[i][rd[i] % RING]);
                        rd[i]++;
                    end
                end
                held[i]   = vout[i] && !rin[i];
                held_v[i] = act;
                if (vin[i] && rout[i]) begin
                    exp_mem[i][wr[i] % RING] = model(NW[i], a_in[i], b_in[i], cin_b[i], sub_b[i]);
                    wr[i]++;
                end
            end
        end
    end

    // Beat presented in cycle 0 on an empty pipe; valid_o must rise in cycle STAGES
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic sub, input logic [34:0] exp);
        int cnt;
        a_in[0]  = {32'b0, a};
        b_in[0]  = {32'b0, b};
        cin_b[0] = c;
        sub_b[0] = sub;
        vin[0]   = 1'b1;
        rin[0]   = 1'b1;
        @(posedge clk);
        #1 vin[0] = 1'b0;
        cnt = 1;
        while (cnt < 20) begin
            @(negedge clk);
            if (vout[0]) break;
            @(posedge clk);
            #1 cnt++;
        end
        check({name, "_latency"}, 67'(cnt), 67'(stages_f(32, 8)));
        check(name, 67'({zo[0], vo[0], co[0], s0}), 67'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        acc;
        logic [3:0]  pat;
        int unsigned sent, base, cyc;
        logic        done;

        rst   = 1'b1;
        vin   = '0;
        rin   = '1;
        cin_b = '0;
        sub_b = '0;
        for (int i = 0; i < 3; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ctrl[%0d]", i), 67'({rout[i], vout[i]}), 67'(2'b10));
            check($sformatf("reset_data[%0d]", i), {zo[i], vo[i], co[i], s_all[i]}, 67'(0));
        end
        @(posedge clk);
        #1;

        directed("add_5_3",   32'h0000_0005, 32'h0000_0003, 1'b0, ADD, {3'b000, 32'h0000_0008});
        directed("ripple",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, ADD, {3'b101, 32'h0000_0000});
        directed("overflow",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ADD, {3'b010, 32'h8000_0000});
        directed("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b0, SUB, {3'b000, 32'hFFFF_FFFE});
        directed("sub_7_5",   32'h0000_0007, 32'h0000_0005, 1'b0, SUB, {3'b001, 32'h0000_0002});

        // Backpressure: 10 beats, ready_i cycling 1,0,0,1
        pat  = 4'b1001;
        sent = 0;
        base = rd[0];
        cyc  = 0;
        while (cyc < 200 && !(sent == 10 && rd[0] - base == 10)) begin
            rin[0] = pat[cyc % 4];
            if (sent < 10) begin
                vin[0]   = 1'b1;
                a_in[0]  = 64'h1000 + 64'(sent);
                b_in[0]  = 64'(sent) * 64'h0101_0101;
                cin_b[0] = sent[0];
                sub_b[0] = sent[1];
            end else begin
                vin[0] = 1'b0;
            end
            @(negedge clk);
            acc = vin[0] && rout[0];
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        vin[0] = 1'b0;
        rin[0] = 1'b1;
        check("bp_beats_in", 67'(sent), 67'(10));
        check("bp_beats_out", 67'(rd[0] - base), 67'(10));

        // Reset with three beats in flight and a fourth presented during reset
        for (int k = 0; k < 3; k++) begin
            vin[0]   = 1'b1;
            a_in[0]  = {$urandom(), $urandom()};
            b_in[0]  = {$urandom(), $urandom()};
            cin_b[0] = 1'($urandom_range(0, 1));
            sub_b[0] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        vin[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst_ctrl[%0d]", i), 67'({rout[i], vout[i]}), 67'(2'b10));
            check($sformatf("midrst_data[%0d]", i), {zo[i], vo[i], co[i], s_all[i]}, 67'(0));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_stale", 67'(vout[0]), 67'(0));
        end
        @(posedge clk);
        #1;

        // Random traffic on all three configurations with randomised handshake
        cyc  = 0;
        done = 1'b0;
        while (cyc < 60000 && !done) begin
            for (int i = 0; i < 3; i++) begin
                rin[i]   = ($urandom_range(0, 3) != 0);
                vin[i]   = (wr[i] < BEATS) && ($urandom_range(0, 3) != 0);
                a_in[i]  = {$urandom(), $urandom()};
                b_in[i]  = {$urandom(), $urandom()};
                case ($urandom_range(0, 7))
                    0: a_in[i] = '1;
                    1: b_in[i] = ~a_in[i];
                    2: b_in[i] = a_in[i];
                    3: a_in[i] = 64'h7FFF_FFFF_FFFF_FFFF >> (64 - NW[i]);
                    default: ;
                endcase
                cin_b[i] = 1'($urandom_range(0, 1));
                sub_b[i] = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            cyc++;
            done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (wr[i] < BEATS || rd[i] != wr[i]) done = 1'b0;
            end
        end
        vin = '0;
        rin = '1;
        if (!done) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL random_timeout: got %0d cycles, expected completion", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("random_beats[%0d] N=%0d SEG=%0d", i, NW[i], SW[i]), 67'(rd[i]), 67'(BEATS));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
